// File: rtl/idex_stage_buf.sv
// Elastic ID/EX pipeline stage: valid/ready on both sides, 2-entry skid buffer,
// synchronous flush with NOP insertion and a saturating backpressure counter.
module idex_stage_buf #(
    parameter int WORD_W = 16,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [WORD_W-1:0] in_sr1,
    input  logic [WORD_W-1:0] in_sr2,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_br_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_sr1,
    output logic [WORD_W-1:0] out_sr2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_br_en,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] sr1;
        logic [WORD_W-1:0] sr2;
        logic [CTRL_W-1:0] ctrl;
        logic              br_en;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    beat_t  main_q, skid_q, in_beat;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid;

    assign in_beat = '{pc: in_pc, instr: in_instr, sr1: in_sr1, sr2: in_sr2,
                       ctrl: in_ctrl, br_en: in_br_en};

    // in_ready looks only at state, flush and reset so no combinational path from out_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = reset & ~flush & (state_q != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_main_in) begin
                    main_q <= in_beat;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_beat;
                end
            end
            if (out_valid && !out_ready && !flush && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign out_pc    = main_q.pc;
    assign out_instr = main_q.instr;
    assign out_sr1   = main_q.sr1;
    assign out_sr2   = main_q.sr2;
    assign out_ctrl  = main_q.ctrl;
    assign out_br_en = main_q.br_en;

endmodule

// File: tb/tb_idex_stage_buf.sv
// Directed bench for idex_stage_buf: streaming, backpressure, flush, async reset
// and counter saturation on a CNT_W=4 instance fed the same inputs.
module tb_idex_stage_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [15:0] in_pc, in_instr, in_sr1, in_sr2;
    logic [31:0] in_ctrl;
    logic        in_br_en;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [15:0] out_pc, out_instr, out_sr1, out_sr2;
    logic [15:0] out_pc4, out_instr4, out_sr1_4, out_sr2_4;
    logic [31:0] out_ctrl, out_ctrl4;
    logic        out_br_en, out_br_en4;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    idex_stage_buf dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_sr1(in_sr1), .in_sr2(in_sr2),
        .in_ctrl(in_ctrl), .in_br_en(in_br_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_sr1(out_sr1), .out_sr2(out_sr2),
        .out_ctrl(out_ctrl), .out_br_en(out_br_en), .stall_cycles(stall_cycles)
    );

    idex_stage_buf #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_instr(in_instr), .in_sr1(in_sr1), .in_sr2(in_sr2),
        .in_ctrl(in_ctrl), .in_br_en(in_br_en),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .out_instr(out_instr4), .out_sr1(out_sr1_4), .out_sr2(out_sr2_4),
        .out_ctrl(out_ctrl4), .out_br_en(out_br_en4), .stall_cycles(stall_cycles4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] sr1);
        in_pc    = pc;
        in_instr = pc ^ 16'h5A00;
        in_sr1   = sr1;
        in_sr2   = ~pc;
        in_ctrl  = {16'hC0DE, pc};
        in_br_en = pc[1];
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(16'h0000, 16'h0000);

        // Reset state, held asserted.
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_pc", 32'(out_pc), 32'h0);
        check("rst_stall", 32'(stall_cycles), 32'h0);
        #11 reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'h1);

        // Stream three beats with out_ready=1.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(16'h0000, 16'h1111);
        tick();
        check("s0_valid", 32'(out_valid), 32'h1);
        check("s0_pc", 32'(out_pc), 32'h0000);
        check("s0_instr", 32'(out_instr), 32'h5A00);
        drive(16'h0002, 16'h2222);
        tick();
        check("s1_valid", 32'(out_valid), 32'h1);
        check("s1_pc", 32'(out_pc), 32'h0002);
        check("s1_ctrl", 32'(out_ctrl), 32'hC0DE0002);
        check("s1_br_en", 32'(out_br_en), 32'h1);
        drive(16'h0004, 16'h3333);
        tick();
        check("s2_pc", 32'(out_pc), 32'h0004);
        check("s2_sr1", 32'(out_sr1), 32'h3333);
        check("s2_sr2", 32'(out_sr2), 32'hFFFB);
        check("s2_br_en", 32'(out_br_en), 32'h0);
        in_valid = 1'b0;
        tick();
        check("s_drain_valid", 32'(out_valid), 32'h0);
        check("s_stall", 32'(stall_cycles), 32'h0);

        // Backpressure fill to FULL, hold, then drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(16'h1000, 16'h0000);
        tick();
        check("bp_one_pc", 32'(out_pc), 32'h1000);
        check("bp_one_stall", 32'(stall_cycles), 32'h0);
        drive(16'h1002, 16'h0000);
        tick();
        check("bp_full_in_ready", 32'(in_ready), 32'h0);
        check("bp_full_pc", 32'(out_pc), 32'h1000);
        check("bp_full_stall", 32'(stall_cycles), 32'h1);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("bp_hold_stall", 32'(stall_cycles), 32'h4);
        check("bp_hold_pc", 32'(out_pc), 32'h1000);
        out_ready = 1'b1;
        tick();
        check("bp_drain0_pc", 32'(out_pc), 32'h1002);
        check("bp_drain0_in_ready", 32'(in_ready), 32'h1);
        check("bp_drain0_stall", 32'(stall_cycles), 32'h4);
        tick();
        check("bp_drain1_valid", 32'(out_valid), 32'h0);

        // Flush while FULL with a competing beat on the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(16'h3000, 16'h0000);
        tick();
        drive(16'h3002, 16'h0000);
        tick();
        check("fl_pre_stall", 32'(stall_cycles), 32'h5);
        drive(16'h2000, 16'h0000);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_instr", 32'(out_instr), 32'h0);
        check("fl_ctrl", 32'(out_ctrl), 32'h0);
        check("fl_in_ready_after", 32'(in_ready), 32'h1);
        check("fl_stall", 32'(stall_cycles), 32'h5);
        tick();
        check("fl_no_ghost_valid", 32'(out_valid), 32'h0);
        check("fl_no_ghost_pc", 32'(out_pc), 32'h0);

        // Simultaneous in_fire and out_fire in ONE.
        in_valid = 1'b1;
        drive(16'h4000, 16'h1234);
        tick();
        check("sim_main_sr1", 32'(out_sr1), 32'h1234);
        out_ready = 1'b1;
        drive(16'h4002, 16'hBEEF);
        tick();
        check("sim_sr1", 32'(out_sr1), 32'hBEEF);
        check("sim_valid", 32'(out_valid), 32'h1);
        check("sim_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        tick();
        check("sim_drain_valid", 32'(out_valid), 32'h0);

        // Async reset between edges while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(16'h5000, 16'hAAAA);
        tick();
        drive(16'h5002, 16'hBBBB);
        tick();
        check("ar_full_in_ready", 32'(in_ready), 32'h0);
        check("ar_pre_stall", 32'(stall_cycles), 32'h6);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_pc", 32'(out_pc), 32'h0);
        check("ar_sr1", 32'(out_sr1), 32'h0);
        check("ar_ctrl", 32'(out_ctrl), 32'h0);
        check("ar_stall", 32'(stall_cycles), 32'h0);
        check("ar_in_ready", 32'(in_ready), 32'h0);
        #3 reset = 1'b1;
        #1;
        check("ar_rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("ar_post_valid", 32'(out_valid), 32'h0);
        check("ar_post_in_ready", 32'(in_ready), 32'h1);

        // Counter saturation: 20 stalled cycles.
        in_valid = 1'b1;
        drive(16'h6000, 16'h0000);
        tick();
        in_valid = 1'b0;
        check("sat_start4", 32'(stall_cycles4), 32'h0);
        for (int i = 0; i < 14; i++) tick();
        check("sat_14_4", 32'(stall_cycles4), 32'hE);
        tick();
        check("sat_15_4", 32'(stall_cycles4), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_20_4", 32'(stall_cycles4), 32'hF);
        check("sat_20_16", 32'(stall_cycles), 32'd20);
        check("sat_pc4", 32'(out_pc4), 32'h6000);
        out_ready = 1'b1;
        tick();
        check("sat_drain_valid4", 32'(out_valid4), 32'h0);
        check("sat_hold_4", 32'(stall_cycles4), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/idex_stage_buf.md
Name: idex_stage_buf

Overview:
- Parametrised elastic ID/EX pipeline stage. Successor to the plain load-enabled pipeline latch.
- Carries PC, instruction, both source operands, the control word and the branch-enable bit.
- Replaces the single `load` with a valid/ready handshake on both sides, backed by a 2-entry skid buffer so `in_ready` never combinationally depends on `out_ready`.
- Adds synchronous flush with NOP insertion and a saturating backpressure counter.

Parameters:
- WORD_W, 16, width of pc/instruction/sr1/sr2 fields.
- CTRL_W, 32, width of the packed control word.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held entries (branch mispredict / exception).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_pc  in  WORD_W  PC of incoming instruction.
- in_instr  in  WORD_W  instruction word.
- in_sr1  in  WORD_W  source operand 1.
- in_sr2  in  WORD_W  source operand 2.
- in_ctrl  in  CTRL_W  control word.
- in_br_en  in  1  branch-enable bit.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts beat.
- out_pc, out_instr, out_sr1, out_sr2  out  WORD_W each  registered payload.
- out_ctrl  out  CTRL_W  registered control word.
- out_br_en  out  1  registered branch-enable.
- stall_cycles  out  CNT_W  count of backpressured cycles.

Behaviour:
- Handshake fire definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - MAIN register drives all out_* fields directly.
  - SKID register holds one overflow beat.
- States:
  - EMPTY: out_valid=0.
  - ONE: MAIN valid.
  - FULL: MAIN and SKID valid.
- out_valid = (state != EMPTY), taken directly from the state register.
- in_ready = ~flush & (state != FULL). Depends only on state and flush, never on out_ready.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, MAIN<=in.
  - ONE, in_fire & out_fire -> ONE, MAIN<=in.
  - ONE, in_fire & ~out_fire -> FULL, SKID<=in.
  - ONE, ~in_fire & out_fire -> EMPTY. MAIN keeps its stale value.
  - ONE, neither -> ONE, hold.
  - FULL: in_ready=0. out_fire -> ONE, MAIN<=SKID. Otherwise hold.
- Ordering: strictly FIFO. Data presented on out_* is always the oldest accepted beat.
- Latency: a beat accepted at edge N into an empty or draining stage is visible on out_* with out_valid=1 after edge N.
- Throughput: sustained 1 beat/cycle while out_ready=1.
- Flush:
  - flush=1 at an edge gives next state EMPTY.
  - MAIN and SKID payloads are cleared to all-zero (NOP, ctrl=0, br_en=0).
  - No beat is accepted that cycle (in_ready forced 0).
  - A simultaneous out_fire still counts as delivered downstream; flush only kills held entries after that edge.
- stall_cycles:
  - +1 on every edge where out_valid=1 & out_ready=0 & flush=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Reset (reset=0, asynchronous):
  - state=EMPTY, out_valid=0, in_ready=0.
  - All out_* payload = 0, SKID = 0, stall_cycles = 0.
  - After release, in_ready=1 from the first cycle.
  - Reset asserted mid-transfer discards all held beats; no partial update.
- Widths: all fields pass through unmodified. No arithmetic except the stall counter.

Test Plan:
- Reset then stream: in_valid=1 with pc=0x0000,0x0002,0x0004, out_ready=1 -> out_pc 0x0000,0x0002,0x0004 on consecutive cycles, out_valid=1 continuously from cycle 1, stall_cycles=0.
- Backpressure fill: accept pc=0x1000 then 0x1002 with out_ready=0 -> state FULL, in_ready=0, out_pc=0x1000; hold 3 cycles -> stall_cycles=4; raise out_ready -> 0x1000 then 0x1002 emitted, in_ready=1 one cycle after the first out_fire.
- Flush while FULL, with in_valid=1 carrying pc=0x2000 -> next cycle out_valid=0, out_instr=0x0000, out_ctrl=0, in_ready=1; beat 0x2000 never appears.
- Simultaneous in_fire & out_fire in ONE with sr1=0xBEEF in, MAIN=0x1234 -> out_sr1=0xBEEF next cycle, state stays ONE.
- Saturation with CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 and holds.
- Async reset asserted between edges while FULL -> out_valid=0 and all outputs 0 immediately, without a clock edge; in_ready=1 on the first cycle after release.
